// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver with mid-bit sampling; bit period is baud_value+1 clocks.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_error output.
module uart_rx (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] baud_value,
   input  logic        rx,
   output logic [7:0]  data_out,
   output logic        data_valid,
   output logic        framing_error,
`ifdef UART_RX_PARITY_EN
   output logic        parity_error,
`endif
   output logic        busy
);

   // state       | meaning
   // S_IDLE      | line idle, waiting for rx_s low
   // S_START     | verifying start bit at half period
   // S_DATA      | shifting in 8 data bits, LSB first
   // S_PARITY    | sampling parity bit (parity build only)
   // S_STOP      | sampling stop bit, emitting byte
   // S_WAIT_HIGH | stop bit was low; hold until line returns high
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t      r_state;
   logic        r_sync1;
   logic        r_rx_s;
   logic [11:0] r_cnt;
   logic [11:0] r_baud_lat;
   logic [2:0]  r_bit_idx;
   logic [7:0]  r_shift;
`ifdef UART_RX_PARITY_EN
   logic        r_par;
`endif
   logic [11:0] w_half;

   assign w_half = {1'b0, r_baud_lat[11:1]};

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_sync1       <= 1'b1;
         r_rx_s        <= 1'b1;
         r_cnt         <= '0;
         r_baud_lat    <= '0;
         r_bit_idx     <= '0;
         r_shift       <= '0;
`ifdef UART_RX_PARITY_EN
         r_par         <= 1'b0;
         parity_error  <= 1'b0;
`endif
         data_out      <= '0;
         data_valid    <= 1'b0;
         framing_error <= 1'b0;
         busy          <= 1'b0;
      end else begin
         r_sync1       <= rx;
         r_rx_s        <= r_sync1;
         data_valid    <= 1'b0;
         framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_error  <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (!r_rx_s) begin
                  r_baud_lat <= baud_value;
                  r_cnt      <= '0;
                  r_state    <= S_START;
                  busy       <= 1'b1;
               end
            end
            S_START: begin
               if (r_cnt == w_half) begin
                  r_cnt <= '0;
                  if (!r_rx_s) begin
                     r_state   <= S_DATA;
                     r_bit_idx <= '0;
                  end else begin
                     r_state <= S_IDLE;
                     busy    <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + 12'd1;
               end
            end
            S_DATA: begin
               if (r_cnt == r_baud_lat) begin
                  r_cnt     <= '0;
                  r_shift   <= {r_rx_s, r_shift[7:1]};
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= S_PARITY;
`else
                     r_state <= S_STOP;
`endif
                  end
               end else begin
                  r_cnt <= r_cnt + 12'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (r_cnt == r_baud_lat) begin
                  r_cnt   <= '0;
                  r_par   <= r_rx_s;
                  r_state <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + 12'd1;
               end
            end
`endif
            S_STOP: begin
               if (r_cnt == r_baud_lat) begin
                  r_cnt    <= '0;
                  data_out <= r_shift;
                  if (r_rx_s) begin
                     data_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     parity_error <= (^r_shift) ^ r_par;
`endif
                     r_state    <= S_IDLE;
                     busy       <= 1'b0;
                  end else begin
                     framing_error <= 1'b1;
                     r_state       <= S_WAIT_HIGH;
                  end
               end else begin
                  r_cnt <= r_cnt + 12'd1;
               end
            end
            S_WAIT_HIGH: begin
               // a held-low line must not look like a stream of start bits
               if (r_rx_s) begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: timing, back-to-back, false start, break, mid-frame reset, parity.
module tb_uart_rx;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] baud_value = 12'd867;
   logic        rx = 1'b1;
   logic [7:0]  data_out;
   logic        data_valid;
   logic        framing_error;
   logic        busy;
`ifdef UART_RX_PARITY_EN
   logic        parity_error;
   localparam int EXTRA = 868;
`else
   localparam int EXTRA = 0;
`endif

   uart_rx dut (
      .clk           (clk),
      .reset         (reset),
      .baud_value    (baud_value),
      .rx            (rx),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .framing_error (framing_error),
`ifdef UART_RX_PARITY_EN
      .parity_error  (parity_error),
`endif
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_valid = 0;
   int         n_ferr  = 0;
   int         n_perr  = 0;
   int         n_perr_with_valid = 0;
   int         n_busy_rise = 0;
   int         n_busy_at_valid = 0;
   int         busy_rise_cyc = 0;
   int         fall_cyc = 0;
   logic       busy_q = 1'b0;
   logic [7:0] v_data [16];
   int         v_cyc  [16];
   logic [7:0] snap_data;
   logic       snap_busy, snap_dv, snap_fe;

   always @(negedge clk) begin
      if (data_valid === 1'b1) begin
         v_data[n_valid & 15] = data_out;
         v_cyc[n_valid & 15]  = cyc;
         if (busy === 1'b1) n_busy_at_valid++;
`ifdef UART_RX_PARITY_EN
         if (parity_error === 1'b1) n_perr_with_valid++;
`endif
         n_valid++;
      end
      if (framing_error === 1'b1) n_ferr++;
`ifdef UART_RX_PARITY_EN
      if (parity_error === 1'b1) n_perr++;
`endif
      if (busy === 1'b1 && busy_q !== 1'b1) begin
         n_busy_rise++;
         busy_rise_cyc = cyc;
      end
      busy_q = busy;
   end

   // rst_bit >= 0 pulses reset for one clock in the middle of that data bit
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic par,
                             input int per, input int rst_bit);
      fall_cyc = cyc;
      rx = 1'b0;
      repeat (per) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         if (i == rst_bit) begin
            repeat (per / 2) @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            snap_data = data_out;
            snap_busy = busy;
            snap_dv   = data_valid;
            snap_fe   = framing_error;
            reset = 1'b1;
            repeat (per - per / 2 - 1) @(negedge clk);
         end else begin
            repeat (per) @(negedge clk);
         end
      end
`ifdef UART_RX_PARITY_EN
      rx = par;
      repeat (per) @(negedge clk);
`else
      if (par === 1'bx) rx = 1'b1;
`endif
      rx = stop;
      repeat (per) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
      n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
      n_tests++; if (framing_error !== 1'b0) begin n_fail++; $display("FAIL reset_framing_error: got %b expected 0", framing_error); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef UART_RX_PARITY_EN
      n_tests++; if (parity_error !== 1'b0) begin n_fail++; $display("FAIL reset_parity_error: got %b expected 0", parity_error); end
`endif
      reset = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_frame();
      int v0, f0, r0, b0, dt_start, dt_fall;
      v0 = n_valid; f0 = n_ferr; r0 = n_busy_rise; b0 = n_busy_at_valid;
      baud_value = 12'd867;
      fork
         send_frame(8'hA5, 1'b1, ^8'hA5, 868, -1);
         begin
            repeat (3000) @(negedge clk);
            baud_value = 12'd7;
         end
      join
      repeat (10) @(negedge clk);
      baud_value = 12'd867;
      n_tests++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL frame_valid_count: got %0d expected 1", n_valid - v0); end
      n_tests++; if (v_data[v0 & 15] !== 8'hA5) begin n_fail++; $display("FAIL frame_data: got %h expected a5", v_data[v0 & 15]); end
      n_tests++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL frame_data_hold: got %h expected a5", data_out); end
      n_tests++; if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL frame_no_ferr: got %0d expected 0", n_ferr - f0); end
      n_tests++; if (n_busy_rise - r0 !== 1) begin n_fail++; $display("FAIL frame_busy_rise: got %0d expected 1", n_busy_rise - r0); end
      dt_start = v_cyc[v0 & 15] - busy_rise_cyc;
      n_tests++; if (dt_start < 8244 + EXTRA || dt_start > 8246 + EXTRA) begin n_fail++; $display("FAIL frame_start_to_valid: got %0d expected %0d+-1", dt_start, 8245 + EXTRA); end
      dt_fall = v_cyc[v0 & 15] - (fall_cyc + 1);
      n_tests++; if (dt_fall < 8246 + EXTRA || dt_fall > 8248 + EXTRA) begin n_fail++; $display("FAIL frame_fall_to_valid: got %0d expected %0d+-1", dt_fall, 8247 + EXTRA); end
      n_tests++; if (n_busy_at_valid - b0 !== 0) begin n_fail++; $display("FAIL frame_busy_drop: busy high at valid %0d times expected 0", n_busy_at_valid - b0); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_busy_idle: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      int v0, dt;
      v0 = n_valid;
      baud_value = 12'd867;
      send_frame(8'h00, 1'b1, 1'b0, 868, -1);
      send_frame(8'hFF, 1'b1, 1'b0, 868, -1);
      repeat (10) @(negedge clk);
      n_tests++; if (n_valid - v0 !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", n_valid - v0); end
      n_tests++; if (v_data[v0 & 15] !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got %h expected 00", v_data[v0 & 15]); end
      n_tests++; if (v_data[(v0 + 1) & 15] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got %h expected ff", v_data[(v0 + 1) & 15]); end
      dt = v_cyc[(v0 + 1) & 15] - v_cyc[v0 & 15];
      n_tests++; if (dt !== 8680 + EXTRA) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", dt, 8680 + EXTRA); end
   endtask

   task automatic test_false_start();
      int v0, f0, r0;
      v0 = n_valid; f0 = n_ferr; r0 = n_busy_rise;
      rx = 1'b0;
      repeat (200) @(negedge clk);
      rx = 1'b1;
      repeat (1000) @(negedge clk);
      n_tests++; if (n_busy_rise - r0 !== 1) begin n_fail++; $display("FAIL false_busy_rise: got %0d expected 1", n_busy_rise - r0); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL false_busy_fall: got %b expected 0", busy); end
      n_tests++; if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL false_no_valid: got %0d expected 0", n_valid - v0); end
      n_tests++; if (n_ferr - f0 !== 0) begin n_fail++; $display("FAIL false_no_ferr: got %0d expected 0", n_ferr - f0); end
   endtask

   task automatic test_break();
      int v0, f0;
      v0 = n_valid; f0 = n_ferr;
      baud_value = 12'd99;
      send_frame(8'h3C, 1'b0, ^8'h3C, 100, -1);
      repeat (20000) @(negedge clk);
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_held: got %b expected 1", busy); end
      n_tests++; if (n_ferr - f0 !== 1) begin n_fail++; $display("FAIL break_ferr_count: got %0d expected 1", n_ferr - f0); end
      n_tests++; if (n_valid - v0 !== 0) begin n_fail++; $display("FAIL break_no_valid: got %0d expected 0", n_valid - v0); end
      n_tests++; if (data_out !== 8'h3C) begin n_fail++; $display("FAIL break_data_out: got %h expected 3c", data_out); end
      rx = 1'b1;
      repeat (10) @(negedge clk);
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break_busy_release: got %b expected 0", busy); end
      send_frame(8'h5A, 1'b1, ^8'h5A, 100, -1);
      repeat (10) @(negedge clk);
      n_tests++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL break_next_count: got %0d expected 1", n_valid - v0); end
      n_tests++; if (v_data[v0 & 15] !== 8'h5A) begin n_fail++; $display("FAIL break_next_data: got %h expected 5a", v_data[v0 & 15]); end
      n_tests++; if (n_ferr - f0 !== 1) begin n_fail++; $display("FAIL break_next_ferr: got %0d expected 1", n_ferr - f0); end
   endtask

   task automatic test_reset_midframe();
      int v0, f0;
      v0 = n_valid; f0 = n_ferr;
      baud_value = 12'd99;
      send_frame(8'hF8, 1'b1, ^8'hF8, 100, 4);
      repeat (10) @(negedge clk);
      n_tests++; if (snap_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data_out: got %h expected 00", snap_data); end
      n_tests++; if (snap_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", snap_busy); end
      n_tests++; if (snap_dv !== 1'b0 || snap_fe !== 1'b0) begin n_fail++; $display("FAIL midrst_pulses: got dv=%b fe=%b expected 0 0", snap_dv, snap_fe); end
      n_tests++; if (n_valid - v0 !== 0 || n_ferr - f0 !== 0) begin n_fail++; $display("FAIL midrst_no_pulse: got valid=%0d ferr=%0d expected 0 0", n_valid - v0, n_ferr - f0); end
      send_frame(8'h81, 1'b1, ^8'h81, 100, -1);
      repeat (10) @(negedge clk);
      n_tests++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL midrst_next_count: got %0d expected 1", n_valid - v0); end
      n_tests++; if (v_data[v0 & 15] !== 8'h81) begin n_fail++; $display("FAIL midrst_next_data: got %h expected 81", v_data[v0 & 15]); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int v0, p0, pv0;
      baud_value = 12'd99;
      v0 = n_valid; p0 = n_perr; pv0 = n_perr_with_valid;
      send_frame(8'h07, 1'b1, 1'b1, 100, -1);
      repeat (10) @(negedge clk);
      n_tests++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL par_good_valid: got %0d expected 1", n_valid - v0); end
      n_tests++; if (n_perr - p0 !== 0) begin n_fail++; $display("FAIL par_good_perr: got %0d expected 0", n_perr - p0); end
      v0 = n_valid; p0 = n_perr; pv0 = n_perr_with_valid;
      send_frame(8'h07, 1'b1, 1'b0, 100, -1);
      repeat (10) @(negedge clk);
      n_tests++; if (n_valid - v0 !== 1) begin n_fail++; $display("FAIL par_bad_valid: got %0d expected 1", n_valid - v0); end
      n_tests++; if (n_perr - p0 !== 1) begin n_fail++; $display("FAIL par_bad_perr: got %0d expected 1", n_perr - p0); end
      n_tests++; if (n_perr_with_valid - pv0 !== 1) begin n_fail++; $display("FAIL par_bad_same_cycle: got %0d expected 1", n_perr_with_valid - pv0); end
      n_tests++; if (v_data[v0 & 15] !== 8'h07) begin n_fail++; $display("FAIL par_bad_data: got %h expected 07", v_data[v0 & 15]); end
   endtask
`endif

   initial begin
      test_reset();
      test_frame();
      test_back_to_back();
      test_false_start();
      test_break();
      test_reset_midframe();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: the far end of the serial line driven by the transmit path clocked from `baudrate_generator`. Takes the same `baud_value` divisor, recovers 8N1 frames (optional parity) from `rx` by mid-bit sampling, and presents each byte with a one-cycle valid strobe. Sits between the board pin and any byte consumer (FIFO, command decoder).

## Interface
- No parameters; the bit period comes from the `baud_value` port.
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `baud_value` input 12: divisor; bit period P = `baud_value`+1 clocks (867 → 868 clk/bit, 57600 baud at 50 MHz). Latched on frame start. Valid range 7..4095.
- `rx` input 1: serial line, idle high, asynchronous to `clk`.
- `data_out` output 8: last received byte.
- `data_valid` output 1: one-cycle pulse; `data_out` is valid while it is high and holds afterwards.
- `framing_error` output 1: one-cycle pulse when the stop bit samples low.
- `busy` output 1: high in any state other than IDLE.
- `parity_error` output 1: only present with `UART_RX_PARITY_EN`.

## Operation
- `rx` passes through a 2-flop synchronizer (both flops reset to 1), giving `rx_s`. All decisions use `rx_s`.
- Counter `cnt`: 12 bits, cleared on every state entry and on every in-state sample. `baud_lat` holds `baud_value` captured on IDLE→START. `half` = `baud_lat`>>1.
- IDLE: when `rx_s`==0, load `baud_lat` and go to START.
- START: when `cnt`==`half`, sample. If `rx_s`==0, go to DATA with bit index 0. If `rx_s`==1, this is a false start: go to IDLE with no output.
- DATA: when `cnt`==`baud_lat`, sample `rx_s` into the shift register, LSB first. After bit 7, go to PARITY if the macro is defined, otherwise to STOP.
- PARITY: when `cnt`==`baud_lat`, sample the parity bit and go to STOP.
- STOP: when `cnt`==`baud_lat`, sample and update `data_out` with the shifted byte.
  - `rx_s`==1: pulse `data_valid` (and `parity_error` if parity mismatched), then go to IDLE.
  - `rx_s`==0: pulse `framing_error`, no `data_valid`, then go to WAIT_HIGH.
- WAIT_HIGH (break or line fault): stay until `rx_s`==1, then go to IDLE. This prevents a held-low line from retriggering continuously.
- Changes to `baud_value` mid-frame have no effect; the new value applies from the next START.

## Timing
- Reset values: `data_out`=0x00, `data_valid`=0, `framing_error`=0, `parity_error`=0, `busy`=0, state IDLE, synchronizer flops = 1.
- An `rx` fall before edge k is seen in `rx_s` at edge k+1. START is entered at edge k+2; `busy` is high from that edge.
- Start-bit sample: `half` clocks after START entry. Each following sample is P clocks after the previous one.
- Stop sample, and therefore the `data_valid`/`framing_error` edge, occurs `half`+9·P clocks after START entry (`half`+10·P with parity). With `baud_value`=867: 8245 clocks without parity, 9113 with.
- `busy` drops on the cycle after the stop-sample edge when the stop bit is good.
- The next frame's start bit can be detected on the first cycle back in IDLE. Back-to-back frames need no idle gap, because the stop sample lands about P/2 before the next start edge.
- Reset low mid-frame: on the next edge, return to IDLE and drive all outputs to their reset values. No partial byte is emitted.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds the PARITY state and the `parity_error` port.
  - Even parity: the error condition is XOR(data bits, parity bit)==1.
  - `data_valid` still pulses on a good stop bit; `parity_error` pulses in the same cycle when parity mismatches.
- Not defined:
  - No PARITY state and no `parity_error` port; frame format is 8N1.

## Test plan
- 8N1 frame: `baud_value`=867, 868 clk/bit, byte 0xA5 → `data_out`=0xA5 with one `data_valid` pulse, 8245±1 clocks after START entry (or 8247±1 after the `rx` fall at the pin); `framing_error` stays 0.
- Back-to-back frames: 0x00 then 0xFF with no idle gap → two `data_valid` pulses, 10·868 clocks apart, values 0x00 then 0xFF.
- False start: `rx` low for 200 clocks, then high → `busy` rises then falls; no `data_valid`, no `framing_error`.
- Framing error and break:
  - Frame 0x3C with stop bit low, then `rx` held low for 20000 clocks → one `framing_error` pulse, `data_out`=0x3C, no `data_valid`, `busy` stays high until `rx` returns high.
  - Next normal frame 0x5A → received correctly.
- Reset mid-frame: `reset`=0 for one clock during bit 4 of a frame → outputs return to reset values; the remainder of the frame produces no pulse; the next frame 0x81 is received correctly.
- `UART_RX_PARITY_EN` build: 0x07 with parity bit 1 → `data_valid`=1, `parity_error`=0. Same byte with parity bit 0 → `data_valid`=1 and `parity_error`=1 in the same cycle.
